// File: rtl/sdrc_req_arb.sv
// sdrc_req_arb: four-port request arbiter in front of the SDRAM request generator.
// Two-class priority, round-robin within a class. Optional aging with SDRC_REQ_ARB_AGE_EN.
`default_nettype none

module sdrc_req_arb #(
   parameter int NUM_PORT     = 4,
   parameter int APP_AW       = 30,
   parameter int APP_RW       = 9,
   parameter int SDR_REQ_ID_W = 4,
   parameter int AGE_W        = 4
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_PORT-1:0]              p_req,
   input  logic [NUM_PORT*SDR_REQ_ID_W-1:0] p_id,
   input  logic [NUM_PORT*(APP_AW+1)-1:0]   p_addr,
   input  logic [NUM_PORT*(APP_AW-1)-1:0]   p_addr_mask,
   input  logic [NUM_PORT*APP_RW-1:0]       p_len,
   input  logic [NUM_PORT-1:0]              p_wr_n,
   input  logic [NUM_PORT-1:0]              p_wrap,
   output logic [NUM_PORT-1:0]              p_ack,
   input  logic [NUM_PORT-1:0]              cfg_hi_pri,
   input  logic [AGE_W-1:0]                 cfg_age_lim,
   output logic                             req,
   output logic [SDR_REQ_ID_W-1:0]          req_id,
   output logic [APP_AW:0]                  req_addr,
   output logic [APP_AW-2:0]                req_addr_mask,
   output logic [APP_RW-1:0]                req_len,
   output logic                             req_wr_n,
   output logic                             req_wrap,
   input  logic                             req_ack,
   output logic [1:0]                       arb_grant,
   output logic                             arb_busy
);

   typedef enum logic [0:0] {
      ARB_IDLE = 1'b0,
      ARB_REQ  = 1'b1
   } arb_state_t;

   arb_state_t                r_state;
   logic                      r_req;
   logic [1:0]                r_grant;
   logic [1:0]                r_last_grant;
   logic [NUM_PORT-1:0]       r_zack;
   logic [SDR_REQ_ID_W-1:0]   r_id;
   logic [APP_AW:0]           r_addr;
   logic [APP_AW-2:0]         r_mask;
   logic [APP_RW-1:0]         r_len;
   logic                      r_wr_n;
   logic                      r_wrap;

   logic [NUM_PORT-1:0]       w_elig;
   logic [NUM_PORT-1:0]       w_hi;
   logic [NUM_PORT-1:0]       w_aged;
   logic [NUM_PORT-1:0]       w_cand;
   logic [NUM_PORT-1:0]       w_fwd_ack;
   logic                      w_found;
   logic [1:0]                w_win;
   logic [APP_RW-1:0]         w_len;
   logic                      w_grant_evt;

   // A port whose zero-length ack is pulsing this cycle still holds p_req; keep it out.
   assign w_elig      = p_req & ~r_zack;
   assign w_hi        = w_elig & cfg_hi_pri;
   assign w_len       = p_len[int'(w_win)*APP_RW +: APP_RW];
   assign w_grant_evt = (r_state == ARB_IDLE) && w_found;

   always_comb begin
      w_cand  = (|w_hi) ? w_hi : w_elig;
      if (|w_aged) begin
         w_cand = w_aged;
      end
      w_found = 1'b0;
      w_win   = 2'd0;
      for (int i = 1; i <= NUM_PORT; i++) begin
         if (!w_found && w_cand[(int'(r_last_grant) + i) % NUM_PORT]) begin
            w_found = 1'b1;
            w_win   = 2'((int'(r_last_grant) + i) % NUM_PORT);
         end
      end
   end

`ifdef SDRC_REQ_ARB_AGE_EN
   for (genvar g = 0; g < NUM_PORT; g++) begin : g_age
      logic [AGE_W-1:0] r_age;

      assign w_aged[g] = w_elig[g] && (cfg_age_lim != '0) && (r_age >= cfg_age_lim);

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            r_age <= '0;
         end else if (!p_req[g] || (w_grant_evt && (w_win == 2'(g)))) begin
            r_age <= '0;
         end else if (w_grant_evt && (r_age != {AGE_W{1'b1}})) begin
            r_age <= r_age + 1'b1;
         end
      end
   end
`else
   wire w_unused_age = ^cfg_age_lim;
   assign w_aged = '0;
`endif

   assign w_fwd_ack = ((r_state == ARB_REQ) && req_ack) ? (NUM_PORT'(1) << r_grant) : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ARB_IDLE;
         r_req        <= 1'b0;
         r_grant      <= 2'd0;
         r_last_grant <= 2'(NUM_PORT - 1);
         r_zack       <= '0;
         r_id         <= '0;
         r_addr       <= '0;
         r_mask       <= '0;
         r_len        <= '0;
         r_wr_n       <= 1'b0;
         r_wrap       <= 1'b0;
      end else begin
         r_zack <= '0;
         case (r_state)
            ARB_IDLE: begin
               if (w_found) begin
                  r_grant <= w_win;
                  r_id    <= p_id[int'(w_win)*SDR_REQ_ID_W +: SDR_REQ_ID_W];
                  r_addr  <= p_addr[int'(w_win)*(APP_AW+1) +: APP_AW+1];
                  r_mask  <= p_addr_mask[int'(w_win)*(APP_AW-1) +: APP_AW-1];
                  r_len   <= w_len;
                  r_wr_n  <= p_wr_n[w_win];
                  r_wrap  <= p_wrap[w_win];
                  // Zero-length transfers complete here without touching the generator.
                  if (w_len == '0) begin
                     r_zack       <= NUM_PORT'(1) << w_win;
                     r_last_grant <= w_win;
                  end else begin
                     r_state <= ARB_REQ;
                     r_req   <= 1'b1;
                  end
               end
            end
            ARB_REQ: begin
               if (req_ack) begin
                  r_last_grant <= r_grant;
                  r_state      <= ARB_IDLE;
                  r_req        <= 1'b0;
               end
            end
            default: begin
               r_state <= ARB_IDLE;
               r_req   <= 1'b0;
            end
         endcase
      end
   end

   assign p_ack         = w_fwd_ack | r_zack;
   assign req           = r_req;
   assign arb_busy      = r_req;
   assign arb_grant     = r_grant;
   assign req_id        = r_id;
   assign req_addr      = r_addr;
   assign req_addr_mask = r_mask;
   assign req_len       = r_len;
   assign req_wr_n      = r_wr_n;
   assign req_wrap      = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_sdrc_req_arb.sv
// tb_sdrc_req_arb: directed vectors, hand sequences and a randomized run against a
// transaction-level arbitration model for sdrc_req_arb.
`default_nettype none

module tb_sdrc_req_arb;
   localparam int NP = 4;
   localparam int AW = 30;
   localparam int RW = 9;
   localparam int IW = 4;
   localparam int GW = 4;

   logic                clk = 1'b0;
   logic                reset = 1'b1;
   logic [NP-1:0]       p_req, p_wr_n, p_wrap, p_ack, cfg_hi_pri;
   logic [NP*IW-1:0]    p_id;
   logic [NP*(AW+1)-1:0] p_addr;
   logic [NP*(AW-1)-1:0] p_addr_mask;
   logic [NP*RW-1:0]    p_len;
   logic [GW-1:0]       cfg_age_lim;
   logic                req, req_wr_n, req_wrap, req_ack, arb_busy;
   logic [IW-1:0]       req_id;
   logic [AW:0]         req_addr;
   logic [AW-2:0]       req_addr_mask;
   logic [RW-1:0]       req_len;
   logic [1:0]          arb_grant;

   // per-port master state
   logic                t_req  [NP];
   logic [IW-1:0]       t_id   [NP];
   logic [AW:0]         t_addr [NP];
   logic [AW-2:0]       t_mask [NP];
   logic [RW-1:0]       t_len  [NP];
   logic                t_wr_n [NP];
   logic                t_wrap [NP];

   int checks   = 0;
   int failures = 0;

   sdrc_req_arb #(.NUM_PORT(NP), .APP_AW(AW), .APP_RW(RW), .SDR_REQ_ID_W(IW), .AGE_W(GW)) dut (
      .clk(clk), .reset(reset), .p_req(p_req), .p_id(p_id), .p_addr(p_addr),
      .p_addr_mask(p_addr_mask), .p_len(p_len), .p_wr_n(p_wr_n), .p_wrap(p_wrap),
      .p_ack(p_ack), .cfg_hi_pri(cfg_hi_pri), .cfg_age_lim(cfg_age_lim), .req(req),
      .req_id(req_id), .req_addr(req_addr), .req_addr_mask(req_addr_mask),
      .req_len(req_len), .req_wr_n(req_wr_n), .req_wrap(req_wrap), .req_ack(req_ack),
      .arb_grant(arb_grant), .arb_busy(arb_busy)
   );

   always #5 clk = ~clk;

   always_comb begin
      p_req = '0; p_id = '0; p_addr = '0; p_addr_mask = '0;
      p_len = '0; p_wr_n = '0; p_wrap = '0;
      for (int i = 0; i < NP; i++) begin
         p_req[i]                  = t_req[i];
         p_id[i*IW +: IW]          = t_id[i];
         p_addr[i*(AW+1) +: AW+1]  = t_addr[i];
         p_addr_mask[i*(AW-1) +: AW-1] = t_mask[i];
         p_len[i*RW +: RW]         = t_len[i];
         p_wr_n[i]                 = t_wr_n[i];
         p_wrap[i]                 = t_wrap[i];
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Master protocol: a request must be held until acknowledged.
   logic [NP-1:0] prev_req = '0, prev_ack = '0;
   logic          prev_rst = 1'b1;
   always @(negedge clk) begin
      if (!reset && !prev_rst) begin
         for (int i = 0; i < NP; i++) begin
            if (prev_req[i] && !prev_ack[i] && !p_req[i]) begin
               failures++;
               $display("FAIL proto port%0d dropped p_req without p_ack", i);
            end
         end
      end
      prev_req = p_req;
      prev_ack = p_ack;
      prev_rst = reset;
   end

   // At most one acknowledge per cycle.
   always @(negedge clk) begin
      if (!reset && !$onehot0(p_ack)) begin
         failures++;
         $display("FAIL ack_onehot actual=%b required=onehot0", p_ack);
      end
   end

   initial begin
      #2_000_000;
      failures++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   task automatic clear_ports();
      for (int i = 0; i < NP; i++) begin
         t_req[i] = 1'b0; t_id[i] = '0; t_addr[i] = '0; t_mask[i] = '0;
         t_len[i] = '0; t_wr_n[i] = 1'b0; t_wrap[i] = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      clear_ports();
      req_ack = 1'b0; cfg_hi_pri = '0; cfg_age_lim = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic set_port(input int i, input int len);
      t_req[i]  = 1'b1;
      t_id[i]   = IW'(i + 5);
      t_addr[i] = 31'h100 + 31'(i) * 31'h1000;
      t_mask[i] = 29'h1234 + 29'(i);
      t_len[i]  = RW'(len);
      t_wr_n[i] = i[0];
      t_wrap[i] = (i == 2);
   endtask

   // ---------------- transaction-level reference model ----------------
   int            m_last, m_grant, m_zack;
   bit            m_busy;
   logic [AW:0]   m_addr;
   logic [RW-1:0] m_len;
   logic [IW-1:0] m_id;
   logic          m_wr_n, m_wrap;
   int            m_age [NP];

   function automatic int rr_pick(input logic [NP-1:0] cand, input int last);
      for (int k = 1; k <= NP; k++) begin
         if (cand[(last + k) % NP]) return (last + k) % NP;
      end
      return -1;
   endfunction

   function automatic logic [NP-1:0] model_cand(input logic [NP-1:0] elig);
      logic [NP-1:0] hi, aged;
      hi   = elig & cfg_hi_pri;
      aged = '0;
`ifdef SDRC_REQ_ARB_AGE_EN
      for (int i = 0; i < NP; i++)
         aged[i] = elig[i] && cfg_age_lim != 0 && m_age[i] >= int'(cfg_age_lim);
`endif
      if (aged != 0) return aged;
      if (hi != 0) return hi;
      return elig;
   endfunction

   typedef struct {
      logic [3:0] mask;
      logic [3:0] hi;
      int         len;
      int         dly;
      int         win;
   } vec_t;

   vec_t tbl [7];
   int   exp_seq [8];

   initial begin
      logic [NP-1:0] e_ack, elig;
      int            w;

      tbl[0] = '{mask: 4'b0001, hi: 4'b0000, len: 8, dly: 0, win: 0};
      tbl[1] = '{mask: 4'b0101, hi: 4'b0100, len: 8, dly: 5, win: 2};
      tbl[2] = '{mask: 4'b0010, hi: 4'b0000, len: 0, dly: 0, win: 1};
      tbl[3] = '{mask: 4'b1100, hi: 4'b0000, len: 3, dly: 1, win: 2};
      tbl[4] = '{mask: 4'b1010, hi: 4'b1000, len: 5, dly: 2, win: 3};
      tbl[5] = '{mask: 4'b1111, hi: 4'b0110, len: 1, dly: 0, win: 1};
      tbl[6] = '{mask: 4'b0110, hi: 4'b0001, len: 7, dly: 0, win: 1};

      clear_ports();
      req_ack = 1'b0; cfg_hi_pri = '0; cfg_age_lim = '0;
      do_reset();

      @(negedge clk);
      chk("reset_req", 64'(req), 0);
      chk("reset_busy", 64'(arb_busy), 0);
      chk("reset_ack", 64'(p_ack), 0);
      chk("reset_grant", 64'(arb_grant), 0);
      chk("reset_addr", 64'(req_addr), 0);

      // ---------------- directed vectors ----------------
      for (int v = 0; v < 7; v++) begin
         do_reset();
         cfg_hi_pri = tbl[v].hi;
         for (int i = 0; i < NP; i++) if (tbl[v].mask[i]) set_port(i, tbl[v].len);
         req_ack = (tbl[v].dly == 0);
         @(negedge clk);
         chk($sformatf("v%0d_req_c0", v), 64'(req), 0);
         if (tbl[v].len == 0) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("v%0d_zack", v), 64'(p_ack), 64'(1 << tbl[v].win));
            chk($sformatf("v%0d_zreq", v), 64'(req), 0);
         end else begin
            for (int c = 1; c <= tbl[v].dly + 1; c++) begin
               @(posedge clk); #1;
               req_ack = (c == tbl[v].dly + 1);
               @(negedge clk);
               chk($sformatf("v%0d_c%0d_req", v, c), 64'(req), 1);
               chk($sformatf("v%0d_c%0d_busy", v, c), 64'(arb_busy), 1);
               chk($sformatf("v%0d_c%0d_grant", v, c), 64'(arb_grant), 64'(tbl[v].win));
               chk($sformatf("v%0d_c%0d_addr", v, c), 64'(req_addr), 64'(t_addr[tbl[v].win]));
               chk($sformatf("v%0d_c%0d_ack", v, c), 64'(p_ack),
                   (c == tbl[v].dly + 1) ? 64'(1 << tbl[v].win) : 64'd0);
            end
            chk($sformatf("v%0d_len", v), 64'(req_len), 64'(tbl[v].len));
            chk($sformatf("v%0d_wr_n", v), 64'(req_wr_n), 64'(t_wr_n[tbl[v].win]));
            chk($sformatf("v%0d_wrap", v), 64'(req_wrap), 64'(t_wrap[tbl[v].win]));
            chk($sformatf("v%0d_id", v), 64'(req_id), 64'(t_id[tbl[v].win]));
            chk($sformatf("v%0d_mask", v), 64'(req_addr_mask), 64'(t_mask[tbl[v].win]));
         end
         @(posedge clk); #1;
         t_req[tbl[v].win] = 1'b0;
         req_ack = 1'b0;
         @(negedge clk);
         chk($sformatf("v%0d_post_ack", v), 64'(p_ack), 0);
         chk($sformatf("v%0d_post_req", v), 64'(req), 0);
      end

      // ---------------- round-robin over all four ports ----------------
      do_reset();
      for (int i = 0; i < NP; i++) set_port(i, 4);
      req_ack = 1'b1;
      exp_seq = '{0, 1, 2, 3, 0, 1, 2, 3};
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (c % 2 == 1) begin
            chk($sformatf("rr_c%0d_grant", c), 64'(arb_grant), 64'(exp_seq[(c - 1) / 2]));
            chk($sformatf("rr_c%0d_ack", c), 64'(p_ack), 64'(1 << exp_seq[(c - 1) / 2]));
         end else begin
            chk($sformatf("rr_c%0d_idle", c), 64'(req), 0);
         end
         @(posedge clk); #1;
      end

      // ---------------- reset during ARB_REQ ----------------
      do_reset();
      set_port(1, 6);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_mid_req_before", 64'(req), 1);
      chk("rst_mid_ack_before", 64'(p_ack), 0);
      #2;
      req_ack = 1'b1;
      reset   = 1'b1;
      #1;
      chk("rst_mid_req", 64'(req), 0);
      chk("rst_mid_ack", 64'(p_ack), 0);
      chk("rst_mid_busy", 64'(arb_busy), 0);
      @(posedge clk); #1;
      clear_ports();
      req_ack = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      set_port(0, 2); set_port(1, 2); set_port(3, 2);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_after_grant", 64'(arb_grant), 0);
      chk("rst_after_req", 64'(req), 1);

`ifdef SDRC_REQ_ARB_AGE_EN
      // ---------------- aging overrides class priority ----------------
      do_reset();
      cfg_hi_pri  = 4'b0001;
      cfg_age_lim = 4'd3;
      set_port(0, 4); set_port(1, 4);
      req_ack = 1'b1;
      exp_seq = '{0, 0, 0, 1, 0, 0, 0, 1};
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         if (c % 2 == 1)
            chk($sformatf("age_c%0d_grant", c), 64'(arb_grant), 64'(exp_seq[(c - 1) / 2]));
         @(posedge clk); #1;
      end
`endif

      // ---------------- randomized run against the model ----------------
      do_reset();
      cfg_age_lim = GW'($urandom_range(4));
      m_last = NP - 1; m_grant = 0; m_zack = -1; m_busy = 0;
      m_addr = '0; m_len = '0; m_id = '0; m_wr_n = 0; m_wrap = 0;
      for (int i = 0; i < NP; i++) m_age[i] = 0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         @(negedge clk);
         e_ack = '0;
         if (m_busy && req_ack) e_ack[m_grant] = 1'b1;
         if (m_zack >= 0) e_ack[m_zack] = 1'b1;
         chk($sformatf("rnd%0d_req", cyc), 64'(req), 64'(m_busy));
         chk($sformatf("rnd%0d_ack", cyc), 64'(p_ack), 64'(e_ack));
         chk($sformatf("rnd%0d_grant", cyc), 64'(arb_grant), 64'(m_grant));
         if (m_busy) begin
            chk($sformatf("rnd%0d_addr", cyc), 64'(req_addr), 64'(m_addr));
            chk($sformatf("rnd%0d_len", cyc), 64'(req_len), 64'(m_len));
            chk($sformatf("rnd%0d_misc", cyc), 64'({req_id, req_wr_n, req_wrap}),
                64'({m_id, m_wr_n, m_wrap}));
         end
         // advance the model over this cycle's inputs
         w = -1;
         if (m_busy) begin
            if (req_ack) begin
               m_last = m_grant;
               m_busy = 0;
            end
            m_zack = -1;
         end else begin
            elig = p_req;
            if (m_zack >= 0) elig[m_zack] = 1'b0;
            m_zack = -1;
            if (elig != 0) begin
               w = rr_pick(model_cand(elig), m_last);
               m_grant = w;
               m_addr = t_addr[w]; m_len = t_len[w]; m_id = t_id[w];
               m_wr_n = t_wr_n[w]; m_wrap = t_wrap[w];
               if (t_len[w] == 0) begin
                  m_zack = w;
                  m_last = w;
               end else begin
                  m_busy = 1;
               end
            end
         end
         for (int i = 0; i < NP; i++) begin
            if (!p_req[i] || i == w) m_age[i] = 0;
            else if (w >= 0 && m_age[i] < (1 << GW) - 1) m_age[i]++;
         end
         @(posedge clk); #1;
         for (int i = 0; i < NP; i++) begin
            if (e_ack[i]) begin
               t_req[i] = 1'b0;
            end else if (!t_req[i] && $urandom_range(3) == 0) begin
               t_req[i]  = 1'b1;
               t_id[i]   = IW'($urandom);
               t_addr[i] = (AW+1)'($urandom);
               t_mask[i] = (AW-1)'($urandom);
               t_len[i]  = ($urandom_range(3) == 0) ? '0 : RW'($urandom);
               t_wr_n[i] = 1'($urandom);
               t_wrap[i] = 1'($urandom);
            end
         end
         req_ack = ($urandom_range(2) != 0);
         if ($urandom_range(15) == 0) cfg_hi_pri = NP'($urandom);
      end

      do_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/sdrc_req_arb.md
Name: sdrc_req_arb

Overview:
- Multi-port request arbiter placed in front of the SDRAM request generator.
- Collects transfer requests from up to four application masters and selects one using two-class priority with round-robin inside each class.
- Registers the winner's request fields and drives the single req/req_ack interface of the request generator.
- Returns a one-cycle acknowledge to the winning port.

Parameters:
- NUM_PORT, 4, number of requesting ports; legal values 2..4; port index is always 2 bits.
- APP_AW, 30, application address width; request address is APP_AW+1 bits.
- APP_RW, 9, request length width.
- SDR_REQ_ID_W, 4, request ID width.
- AGE_W, 4, aging counter width (optional feature only).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- p_req  in  NUM_PORT  per-port request; held stable until the matching p_ack.
- p_id  in  NUM_PORT*SDR_REQ_ID_W  per-port request ID, packed, port 0 in the LSBs.
- p_addr  in  NUM_PORT*(APP_AW+1)  per-port SDRAM address, packed.
- p_addr_mask  in  NUM_PORT*(APP_AW-1)  per-port address wrap mask, packed.
- p_len  in  NUM_PORT*APP_RW  per-port length, packed.
- p_wr_n  in  NUM_PORT  0 = write, 1 = read.
- p_wrap  in  NUM_PORT  wrap mode.
- p_ack  out  NUM_PORT  one-hot, one-cycle acknowledge.
- cfg_hi_pri  in  NUM_PORT  1 = port is in the high-priority class.
- cfg_age_lim  in  AGE_W  aging threshold (used only when the optional feature is enabled).
- req  out  1  request to the request generator.
- req_id  out  SDR_REQ_ID_W  registered ID of the winner.
- req_addr  out  APP_AW+1  registered address of the winner.
- req_addr_mask  out  APP_AW-1  registered address mask of the winner.
- req_len  out  APP_RW  registered length of the winner.
- req_wr_n  out  1  registered direction of the winner.
- req_wrap  out  1  registered wrap mode of the winner.
- req_ack  in  1  acceptance from the request generator (combinational on its side).
- arb_grant  out  2  index of the current or last winner.
- arb_busy  out  1  high while in ARB_REQ.

Behaviour:
- Reset: all outputs and registers clear to 0, state = ARB_IDLE.
  - last_grant resets to NUM_PORT-1, so port 0 wins first.
  - Reset asserted mid-transaction drops req and p_ack immediately. No ack is issued for the aborted request.
- States:
  - ARB_IDLE: if (p_req & port_valid) != 0, select a winner; register its fields into the req_* outputs; set arb_grant; go to ARB_REQ. Otherwise stay.
  - ARB_REQ: req = 1, arb_busy = 1.
    - When req_ack = 1: p_ack[arb_grant] = 1 in the same cycle (combinational); last_grant <= arb_grant; next state ARB_IDLE.
    - req_id, req_addr, req_addr_mask, req_len, req_wr_n, req_wrap stay frozen while in ARB_REQ.
- Selection order:
  1. If any requesting port has cfg_hi_pri = 1, only high-priority requesters compete.
  2. Within the competing set, round-robin: search starting at last_grant+1, modulo NUM_PORT; the first requester found wins.
- Zero-length request (p_len field == 0):
  - Never forwarded to the request generator.
  - Acked directly from ARB_IDLE in the cycle it wins: p_ack pulses, last_grant updates, state stays ARB_IDLE, req stays 0.
- Latency:
  - p_req rising in cycle N (in ARB_IDLE) -> req = 1 in cycle N+1.
  - Earliest p_ack is in cycle N+1, when req_ack is already high.
  - Back-to-back grants: one ARB_IDLE cycle between consecutive forwarded requests.
- Ports with index >= NUM_PORT are ignored (port_valid mask).
- p_req deasserting before its p_ack violates the protocol; behaviour is undefined. Verification flags it with an assertion.
- cfg_hi_pri changes take effect at the next ARB_IDLE selection only.
- At most one p_ack bit is high in any cycle.

Optional Feature:
- Macro: SDRC_REQ_ARB_AGE_EN.
- With the macro:
  - Each port has an AGE_W-bit saturating counter.
  - The counter increments on every grant (forwarded or zero-length) given to another port while this port's p_req = 1.
  - The counter clears when the port is granted or when its p_req = 0.
  - A port with counter >= cfg_age_lim (and cfg_age_lim != 0) is "aged". Aged ports outrank both classes; ties go to round-robin order among the aged ports.
  - Reset clears all counters.
- Without the macro: no counters exist, cfg_age_lim is ignored, and selection is pure class priority plus round-robin.

Test Plan:
- Single port 0 request, addr 0x100, len 8, wr_n 0; req_ack tied high -> req high cycle 1 with req_addr = 0x100, req_len = 8, req_wr_n = 0; p_ack = 4'b0001 in cycle 1; arb_grant = 0.
- All four ports requesting continuously, cfg_hi_pri = 0, req_ack high -> grant order 0,1,2,3,0 with one idle cycle between consecutive grants.
- cfg_hi_pri = 4'b0100, ports 0 and 2 requesting, req_ack delayed 5 cycles -> port 2 granted; req and fields held stable for 5 cycles; p_ack = 4'b0100 in the same cycle as req_ack.
- Port 1 requests with p_len = 0 -> p_ack[1] pulses in the cycle after p_req rises; req never asserts.
- reset asserted while in ARB_REQ with req_ack = 0 -> req, p_ack and arb_busy go to 0 immediately; after release, port 0 is the first winner.
- With SDRC_REQ_ARB_AGE_EN, cfg_hi_pri = 4'b0001, cfg_age_lim = 3, ports 0 and 1 requesting -> port 1 wins after 3 grants to port 0; its counter then clears.
